// File: rtl/simon_key_expand_seq_if.sv
// -----------------------------------------------------------------------------
// simon_key_expand_seq_if
// Bundles the request/response signals of the SIMON 64/128 key-schedule engine.
//
// Signals:
//   start      request pulse; key_seed is sampled on the same edge
//   key_seed   128-bit master key (LS word = round key 1, MS word = round key 4)
//   busy       engine is expanding keys
//   keys_valid rk_flat holds a complete key set
//   rk_flat    ROUNDS*KW round keys, MS word = key 1, LS word = key ROUNDS
//   zeroize    (only with SIMON_KS_ZEROIZE_EN) synchronous key-bank wipe
//
// Modports:
//   master  requester side (drives start/key_seed/zeroize)
//   slave   key-schedule engine side
//
// Optional feature macro: SIMON_KS_ZEROIZE_EN
// -----------------------------------------------------------------------------
interface simon_key_expand_seq_if #(
  parameter int ROUNDS = 44,
  parameter int KW     = 32
);
  logic                   start;
  logic [4*KW-1:0]        key_seed;
  logic                   busy;
  logic                   keys_valid;
  logic [ROUNDS*KW-1:0]   rk_flat;
`ifdef SIMON_KS_ZEROIZE_EN
  logic                   zeroize;

  modport master (
    output start, key_seed, zeroize,
    input  busy, keys_valid, rk_flat
  );

  modport slave (
    input  start, key_seed, zeroize,
    output busy, keys_valid, rk_flat
  );
`else
  modport master (
    output start, key_seed,
    input  busy, keys_valid, rk_flat
  );

  modport slave (
    input  start, key_seed,
    output busy, keys_valid, rk_flat
  );
`endif
endinterface

// File: rtl/simon_key_expand_seq.sv
// -----------------------------------------------------------------------------
// simon_key_expand_seq
// Sequential SIMON 64/128 key schedule. On start, the four seed words become
// round keys 1..4; each following clock produces one more round key until key
// ROUNDS is written, after which the full bank is presented with keys_valid.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (clears state, counter and key bank)
//   bus    simon_key_expand_seq_if.slave
//            start, key_seed (in); busy, keys_valid, rk_flat (out)
//            zeroize (in, only with SIMON_KS_ZEROIZE_EN)
//
// Optional feature macro: SIMON_KS_ZEROIZE_EN
//   Adds a synchronous zeroize input that wipes the key bank and returns the
//   engine to IDLE; it has priority over start.
// -----------------------------------------------------------------------------
module simon_key_expand_seq #(
  parameter int ROUNDS = 44,
  parameter int KW     = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  simon_key_expand_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXPAND = 2'd1,
    DONE   = 2'd2
  } state_t;

  // z3 sequence, MS bit = index 0. Padded with two zero LSBs so that any
  // 6-bit select stays inside the vector.
  localparam logic [61:0] Z3 =
    62'b1101101110_1011000110_0101111000_0001001000_1010011100_1101000011_11;
  localparam logic [63:0] Z3_PAD = {Z3, 2'b00};

  // Rotate right within one key word.
  function automatic logic [KW-1:0] ror(input logic [KW-1:0] v, input int unsigned n);
    return (v >> n) | (v << (KW - n));
  endfunction

  state_t               state_r;
  state_t               state_s;
  logic [5:0]           idx_r;        // 1-based index of the next key to write
  logic [KW-1:0]        win_r [0:3];  // [0]=k[i-4] .. [3]=k[i-1]
  logic [ROUNDS*KW-1:0] rk_r;
  logic                 busy_r;
  logic                 valid_r;

  logic                 zero_s;
  logic                 load_s;
  logic                 step_s;
  logic                 clear_s;
  logic [KW-1:0]        t0_s;
  logic [KW-1:0]        t1_s;
  logic [5:0]           z_sel_s;
  logic                 z_s;
  logic [KW-1:0]        key_nxt_s;

`ifdef SIMON_KS_ZEROIZE_EN
  assign zero_s = bus.zeroize;
`else
  assign zero_s = 1'b0;
`endif

  // Next-state decode and datapath control strobes.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    step_s  = 1'b0;
    clear_s = 1'b0;
    if (zero_s) begin
      clear_s = 1'b1;
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (bus.start) begin
            load_s  = 1'b1;
            state_s = EXPAND;
          end else begin
            state_s = state_r;
          end
        end
        EXPAND: begin
          // start is deliberately ignored while expanding.
          step_s = 1'b1;
          if (idx_r == 6'(ROUNDS)) begin
            state_s = DONE;
          end else begin
            state_s = EXPAND;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Round-key recurrence for key idx_r from the sliding window.
  always_comb begin
    t0_s      = ror(win_r[3], 3) ^ win_r[1];
    t1_s      = t0_s ^ ror(t0_s, 1);
    // Key i uses z3 bit (i-5); bit j lives at Z3_PAD[63-j].
    z_sel_s   = 6'd63 - (idx_r - 6'd5);
    z_s       = Z3_PAD[z_sel_s];
    key_nxt_s = ~win_r[0] ^ t1_s ^ {{(KW-1){1'b0}}, z_s} ^ {{(KW-2){1'b0}}, 2'b11};
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Key bank, sliding window, index counter and registered status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_r   <= 6'd0;
      rk_r    <= '0;
      busy_r  <= 1'b0;
      valid_r <= 1'b0;
      for (int w = 0; w < 4; w++) begin
        win_r[w] <= '0;
      end
    end else begin
      busy_r  <= (state_s == EXPAND);
      valid_r <= (state_s == DONE);
      if (clear_s) begin
        idx_r <= 6'd0;
        rk_r  <= '0;
        for (int w = 0; w < 4; w++) begin
          win_r[w] <= '0;
        end
      end else if (load_s) begin
        idx_r    <= 6'd5;
        win_r[0] <= bus.key_seed[KW-1:0];
        win_r[1] <= bus.key_seed[2*KW-1:KW];
        win_r[2] <= bus.key_seed[3*KW-1:2*KW];
        win_r[3] <= bus.key_seed[4*KW-1:3*KW];
        // Keys 1..4 occupy the top four words; keys 5..ROUNDS are left as-is.
        rk_r[ROUNDS*KW-1 -: 4*KW] <= {bus.key_seed[KW-1:0],
                                       bus.key_seed[2*KW-1:KW],
                                       bus.key_seed[3*KW-1:2*KW],
                                       bus.key_seed[4*KW-1:3*KW]};
      end else if (step_s) begin
        idx_r    <= idx_r + 6'd1;
        win_r[0] <= win_r[1];
        win_r[1] <= win_r[2];
        win_r[2] <= win_r[3];
        win_r[3] <= key_nxt_s;
        for (int n = 4; n < ROUNDS; n++) begin
          if (idx_r == 6'(n + 1)) begin
            rk_r[(ROUNDS-1-n)*KW +: KW] <= key_nxt_s;
          end
        end
      end else begin
        idx_r <= idx_r;
      end
    end
  end

  assign bus.busy       = busy_r;
  assign bus.keys_valid = valid_r;
  assign bus.rk_flat    = rk_r;

endmodule

// File: tb/tb_simon_key_expand_seq.sv
// -----------------------------------------------------------------------------
// tb_simon_key_expand_seq
// Directed bench for the SIMON 64/128 key-schedule engine. Expected keys come
// from a bench-side reference expansion; the official vector is further
// cross-checked by encrypting the published plaintext with the DUT key bank.
// -----------------------------------------------------------------------------
module tb_simon_key_expand_seq;

  localparam int ROUNDS = 44;
  localparam int KW     = 32;
  localparam logic [127:0] OFF_SEED = 128'h1b1a1918_13121110_0b0a0908_03020100;
  localparam logic [63:0]  OFF_PT   = 64'h656b696c_20646e75;
  localparam logic [63:0]  OFF_CT   = 64'h44c8fc20_b9dfa07a;

  logic clk;
  logic rst_n;
  int   assert_cnt;
  int   fail_cnt;

  simon_key_expand_seq_if #(.ROUNDS(ROUNDS), .KW(KW)) bus_if ();

  simon_key_expand_seq #(.ROUNDS(ROUNDS), .KW(KW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1407:0] model_expand(input logic [127:0] seed);
    logic [31:0]   k [1:44];
    logic [31:0]   t;
    logic [1407:0] f;
    string         z;
    z    = "11011011101011000110010111100000010010001010011100110100001111";
    k[1] = seed[31:0];
    k[2] = seed[63:32];
    k[3] = seed[95:64];
    k[4] = seed[127:96];
    for (int i = 5; i <= 44; i++) begin
      t    = {k[i-1][2:0], k[i-1][31:3]} ^ k[i-3];
      t    = t ^ {t[0], t[31:1]};
      k[i] = ~k[i-4] ^ t ^ 32'h0000_0003 ^ ((z[i-5] == "1") ? 32'h0000_0001 : 32'h0000_0000);
    end
    f = '0;
    for (int i = 1; i <= 44; i++) begin
      f[(44-i)*32 +: 32] = k[i];
    end
    return f;
  endfunction

  function automatic logic [63:0] simon_enc(input logic [63:0] pt, input logic [1407:0] rk);
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] tmp;
    x = pt[63:32];
    y = pt[31:0];
    for (int i = 1; i <= 44; i++) begin
      tmp = x;
      x   = y ^ ({x[30:0], x[31]} & {x[23:0], x[31:24]}) ^ {x[29:0], x[31:30]}
              ^ rk[(44-i)*32 +: 32];
      y   = tmp;
    end
    return {x, y};
  endfunction

  function automatic logic [31:0] key_of(input logic [1407:0] f, input int n);
    return f[(44-n)*32 +: 32];
  endfunction

  task automatic chk(input string tag, input logic [1407:0] obs, input logic [1407:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Start an expansion and walk through all 40 expansion edges, checking the
  // busy/valid waveform each cycle and the full key bank at the end.
  task automatic run_expand(input logic [127:0] seed, input bit scramble, input int poke_at);
    logic [1407:0] exp_rk;
    exp_rk = model_expand(seed);
    bus_if.key_seed = seed;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    chk("start_busy",  {1407'd0, bus_if.busy},       {1407'd0, 1'b1});
    chk("start_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    for (int c = 1; c <= 40; c++) begin
      if (scramble) begin
        bus_if.key_seed = {$urandom, $urandom, $urandom, $urandom};
      end
      bus_if.start = (c == poke_at);
      tick();
      bus_if.start = 1'b0;
      chk($sformatf("busy_c%0d", c),  {1407'd0, bus_if.busy},       {1407'd0, (c < 40)});
      chk($sformatf("valid_c%0d", c), {1407'd0, bus_if.keys_valid}, {1407'd0, (c == 40)});
      if (c == 1) begin
        chk("key5_c1", {1376'd0, key_of(bus_if.rk_flat, 5)}, {1376'd0, key_of(exp_rk, 5)});
      end
    end
    chk("rk_full", bus_if.rk_flat, exp_rk);
    bus_if.key_seed = seed;
  endtask

  initial begin
    logic [1407:0] snap_exp;
    assert_cnt      = 0;
    fail_cnt        = 0;
    rst_n           = 1'b0;
    bus_if.start    = 1'b0;
    bus_if.key_seed = '0;
`ifdef SIMON_KS_ZEROIZE_EN
    bus_if.zeroize  = 1'b0;
`endif

    // Reset state.
    #12;
    chk("rst_busy",  {1407'd0, bus_if.busy},       {1407'd0, 1'b0});
    chk("rst_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    chk("rst_rk",    bus_if.rk_flat, '0);
    #11;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("idle_busy", {1407'd0, bus_if.busy}, {1407'd0, 1'b0});
    end

    // Official vector with an ignored start pulse at EXPAND cycle 10.
    run_expand(OFF_SEED, 1'b0, 10);
    chk("off_k1_4", {1280'd0, bus_if.rk_flat[1407 -: 128]},
        {1280'd0, 128'h03020100_0b0a0908_13121110_1b1a1918});
    chk("off_k5",   {1376'd0, key_of(bus_if.rk_flat, 5)}, {1376'd0, 32'h70a011c3});
    chk("off_ct",   {1344'd0, simon_enc(OFF_PT, bus_if.rk_flat)}, {1344'd0, OFF_CT});

    // DONE holds indefinitely without start.
    for (int c = 0; c < 5; c++) begin
      tick();
    end
    chk("hold_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b1});
    chk("hold_rk",    bus_if.rk_flat, model_expand(OFF_SEED));

    // Restart from DONE with an all-zero seed.
    bus_if.key_seed = '0;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    chk("rs_valid_drop", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    chk("rs_k1_4", {1280'd0, bus_if.rk_flat[1407 -: 128]}, {1280'd0, 128'h0});
    chk("rs_k5_old", {1376'd0, key_of(bus_if.rk_flat, 5)}, {1376'd0, 32'h70a011c3});
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) begin
        chk("rs_k5", {1376'd0, key_of(bus_if.rk_flat, 5)}, {1376'd0, 32'hfffffffd});
      end
      chk("rs_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, (c == 40)});
    end
    chk("rs_rk", bus_if.rk_flat, model_expand(128'h0));

    // Seed changing every cycle during EXPAND must not disturb the result.
    run_expand(OFF_SEED, 1'b1, 0);
    chk("hold_seed_ct", {1344'd0, simon_enc(OFF_PT, bus_if.rk_flat)}, {1344'd0, OFF_CT});

    // Reset asserted at EXPAND cycle 20.
    bus_if.key_seed = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick();
    end
    chk("mid_busy_pre", {1407'd0, bus_if.busy}, {1407'd0, 1'b1});
    #3;
    rst_n = 1'b0;
    #1;
    chk("mid_busy",  {1407'd0, bus_if.busy},       {1407'd0, 1'b0});
    chk("mid_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    chk("mid_rk",    bus_if.rk_flat, '0);
    #2;
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("post_busy", {1407'd0, bus_if.busy},       {1407'd0, 1'b0});
      chk("post_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    end
    chk("post_rk", bus_if.rk_flat, '0);

`ifdef SIMON_KS_ZEROIZE_EN
    // Zeroize while in DONE.
    run_expand(OFF_SEED, 1'b0, 0);
    bus_if.zeroize = 1'b1;
    tick();
    bus_if.zeroize = 1'b0;
    chk("zd_busy",  {1407'd0, bus_if.busy},       {1407'd0, 1'b0});
    chk("zd_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    chk("zd_rk",    bus_if.rk_flat, '0);
    // Zeroize together with start in IDLE: start is dropped.
    bus_if.key_seed = OFF_SEED;
    bus_if.zeroize  = 1'b1;
    bus_if.start    = 1'b1;
    tick();
    bus_if.zeroize  = 1'b0;
    bus_if.start    = 1'b0;
    chk("zs_busy",  {1407'd0, bus_if.busy},       {1407'd0, 1'b0});
    chk("zs_valid", {1407'd0, bus_if.keys_valid}, {1407'd0, 1'b0});
    chk("zs_rk",    bus_if.rk_flat, '0);
    tick();
    chk("zs_idle",  {1407'd0, bus_if.busy},       {1407'd0, 1'b0});
`endif

    snap_exp = '0;
    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule

// File: doc/simon_key_expand_seq.md
Name: simon_key_expand_seq

Overview:
- Sequential SIMON 64/128 key-schedule engine; sits directly upstream of the 44-round encrypt datapath.
- Expands a 128-bit key seed into 44 32-bit round keys, one key per clock, and holds them in a register bank.
- Presents the keys as a flat bus with a valid flag, replacing the purely combinational key generator.

Parameters:
- ROUNDS, 44, number of round keys produced; the fixed value for 64/128. Any other value is unsupported.
- KW, 32, round-key word width; fixed at 32.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  1-cycle request; samples key_seed. Honoured in IDLE and DONE.
- key_seed  in  128  master key; least-significant 32 bits = round key 1, next = key 2, then key 3; most-significant 32 bits = key 4.
- busy  out  1  high while in EXPAND.
- keys_valid  out  1  high in DONE; rk_flat is stable and complete.
- rk_flat  out  ROUNDS*KW  round keys; most-significant word = key 1, least-significant word = key 44.

Behaviour:
- Reset (async assert, sync release): state IDLE; busy=0; keys_valid=0; rk_flat=0; counter=0.
- States: IDLE, EXPAND, DONE.
- IDLE to EXPAND when start=1. At that edge, keys 1..4 are loaded from key_seed and the index is set to 5.
- EXPAND: each edge writes key[i] and increments i. The start input is ignored.
- When key 44 is written, the state moves to DONE.
  - Key 44 is written on the 40th edge after the start edge.
  - keys_valid rises in the same cycle busy falls.
- DONE to EXPAND when start=1: reloads as from IDLE and clears keys_valid at that edge. Otherwise DONE holds indefinitely.
- Key recurrence, for i = 5..44, 1-indexed:
  - t = ROR3(k[i-1]) XOR k[i-3]
  - t = t XOR ROR1(t)
  - k[i] = NOT k[i-4] XOR t XOR z3[(i-5) mod 62] XOR 3
  - The z3 bit enters at bit 0 only.
- z3 is the 62-bit constant read left-to-right from index 0: 11011011101011000110010111100000010010001010011100110100001111.
- Only 40 z3 bits are consumed. They are held as a constant, not a shift register.
- key_seed is sampled only at the start edge. Later changes to key_seed have no effect.
- Keys not yet written during EXPAND keep their previous values. Consumers use the keys only while keys_valid=1.
- rst_n asserted mid-EXPAND: return to IDLE immediately and clear all outputs. No partial keys remain on rk_flat.
- All arithmetic is modulo 2^32. Rotations are within the 32-bit word.

Optional Feature:
- Macro: SIMON_KS_ZEROIZE_EN.
- Defined:
  - Adds input port zeroize (1 bit, synchronous), which has priority over start.
  - When zeroize=1 at an edge in any state: all key registers are cleared to 0, keys_valid=0, busy=0, and the next state is IDLE.
  - If start and zeroize are both 1, zeroize wins and start is dropped.
- Undefined: the port is absent and the key bank is cleared only by rst_n.

Test Plan:
- Official vector:
  - Stimulus: key_seed = 1b1a1918_13121110_0b0a0908_03020100, start pulse.
  - Response: keys 1..4 = 03020100, 0b0a0908, 13121110, 1b1a1918; key 5 = 70a011c3.
  - keys_valid rises exactly 40 cycles after the start edge.
  - Feeding rk_flat to the encrypt datapath with PT 656b696c_20646e75 yields CT 44c8fc20_b9dfa07a.
- Busy/valid timing: busy=1 for exactly 40 cycles and keys_valid=0 throughout. A start pulse at cycle 10 of EXPAND is ignored and the key 44 result is unchanged.
- Restart from DONE: after the official vector, start with key_seed=0.
  - keys_valid drops at the next edge and returns 40 cycles later.
  - Key 1..4 = 0. Key 5 = NOT(0) XOR 0 XOR 1 XOR 3 = fffffffd.
- Seed hold: change key_seed every cycle during EXPAND. The final keys match the official vector.
- Reset mid-operation: assert rst_n=0 at EXPAND cycle 20.
  - busy, keys_valid and rk_flat go to 0 asynchronously.
  - After release, the state is IDLE and no activity occurs without start.
- Zeroize (SIMON_KS_ZEROIZE_EN): zeroize in DONE and zeroize together with start in IDLE.
  - In both cases rk_flat=0, keys_valid=0 and busy=0 on the next cycle.
